// File: rtl/mc_control_fsm.sv
// Multi-cycle CPU control sequencer: fetch/decode/exec/mem/writeback with a
// memory-handshake timeout, an illegal-opcode trap and a retired-instruction counter.
module mc_control_fsm #(
  parameter int OPW  = 6,
  parameter int CNTW = 16,
  parameter int TMO  = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OPW-1:0]  opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic [10:0]     c_sig,
  output logic            ir_we,
  output logic            pc_we,
  output logic [2:0]      state,
  output logic            instr_done,
  output logic [CNTW-1:0] retired,
  output logic            trap,
  output logic [1:0]      trap_cause
);

  // state | meaning
  // FETCH | wait for mem_ready, load IR, bump PC
  // DECODE| latch decoded control word, route by opcode
  // EXEC  | ALU cycle; branches/jumps retire here
  // MEM   | wait for mem_ready; stores retire here
  // WB    | register write, retire
  // TRAP  | absorbing fault state, left only by reset
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [7:0]      WAIT_LAST = 8'(TMO - 1);
  localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);

  logic [2:0]      state_q, state_d;
  logic [10:0]     ctrl_q, ctrl_d;
  logic [7:0]      wait_q, wait_d;
  logic [CNTW-1:0] retired_q, retired_d;
  logic            trap_q, trap_d;
  logic [1:0]      cause_q, cause_d;

  logic [10:0] dec_word;
  logic        dec_legal;
  logic        ir_we_c, pc_we_c, retire_c, timeout_c;

  always_comb begin
    dec_word  = 11'h000;
    dec_legal = 1'b1;
    case (opcode)
      OPW'(1): dec_word = 11'h001;
      OPW'(2): dec_word = 11'h249;
      OPW'(3): dec_word = 11'h251;
      OPW'(4): dec_word = 11'h259;
      OPW'(5): dec_word = 11'h538;
      OPW'(6): dec_word = 11'h4B8;
      OPW'(7): dec_word = 11'h24A;
      OPW'(8): dec_word = 11'h24D;
      OPW'(9): dec_word = 11'h038;
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    trap_d    = trap_q;
    cause_d   = cause_q;
    ir_we_c   = 1'b0;
    pc_we_c   = 1'b0;
    retire_c  = 1'b0;
    timeout_c = !mem_ready && (wait_q == WAIT_LAST);
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_c) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_DECODE: begin
        ctrl_d = dec_word;
        if (!dec_legal) begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end else if (opcode == OPW'(9)) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // pc bit marks beq/jump; j forces the PC write, b makes it conditional
        if (ctrl_q[10]) begin
          pc_we_c  = ctrl_q[7] | (ctrl_q[8] & zero);
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end else if (ctrl_q[2] | ctrl_q[1]) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (ctrl_q[1]) begin
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_c) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_WB: begin
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP: ;
      default: state_d = S_TRAP;
    endcase
    if (state_d == S_TRAP) trap_d = 1'b1;
    // counter only runs while parked in a handshake state; any transition clears it
    if ((state_d == state_q) && ((state_q == S_FETCH) || (state_q == S_MEM)))
      wait_d = wait_q + 8'd1;
    else
      wait_d = 8'd0;
    retired_d = retire_c ? retired_q + CNT_ONE : retired_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      ctrl_q    <= 11'h000;
      wait_q    <= 8'd0;
      retired_q <= '0;
      trap_q    <= 1'b0;
      cause_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
    end
  end

  always_comb begin
    c_sig = 11'h000;
    case (state_q)
      S_EXEC:  c_sig = ctrl_q & 11'h7F8;
      S_MEM:   c_sig = ctrl_q & 11'h7FE;
      S_WB:    c_sig = ctrl_q & 11'h7F9;
      default: c_sig = 11'h000;
    endcase
  end

  // strobes are combinational from mem_ready, so mask them while reset is held
  assign ir_we      = ir_we_c & rst_n;
  assign pc_we      = pc_we_c & rst_n;
  assign instr_done = retire_c & rst_n;
  assign state      = state_q;
  assign retired    = retired_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: directed scenarios plus randomized
// instruction streams checked cycle by cycle against a transaction-level model.
module tb_mc_control_fsm;
  localparam int OPW  = 6;
  localparam int CNTW = 4;
  localparam int TMO  = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [OPW-1:0]  opcode = '0;
  logic            zero = 1'b0;
  logic            mem_ready = 1'b0;
  logic [10:0]     c_sig;
  logic            ir_we, pc_we, instr_done, trap;
  logic [2:0]      state;
  logic [CNTW-1:0] retired;
  logic [1:0]      trap_cause;

  int checks = 0;
  int failures = 0;
  int exp_ret = 0;
  logic [10:0] word_tab [0:15];

  mc_control_fsm #(.OPW(OPW), .CNTW(CNTW), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .c_sig(c_sig), .ir_we(ir_we), .pc_we(pc_we), .state(state),
    .instr_done(instr_done), .retired(retired), .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [OPW-1:0] ro();
    return OPW'($urandom);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input logic [2:0] es, input logic [10:0] ec, input logic eir,
                         input logic epc, input logic edone, input logic etrap,
                         input logic [1:0] ecause);
    chk("state", 32'(state), 32'(es));
    chk("c_sig", 32'(c_sig), 32'(ec));
    chk("ir_we", 32'(ir_we), 32'(eir));
    chk("pc_we", 32'(pc_we), 32'(epc));
    chk("instr_done", 32'(instr_done), 32'(edone));
    chk("retired", 32'(retired), 32'(exp_ret % (1 << CNTW)));
    chk("trap", 32'(trap), 32'(etrap));
    chk("trap_cause", 32'(trap_cause), 32'(ecause));
  endtask

  // one clock cycle: drive inputs just after negedge, check, advance to next negedge
  task automatic step(input logic mr, input logic [OPW-1:0] op, input logic z,
                      input logic [2:0] es, input logic [10:0] ec, input logic eir,
                      input logic epc, input logic edone, input logic etrap,
                      input logic [1:0] ecause);
    mem_ready = mr;
    opcode    = op;
    zero      = z;
    #1;
    chk_all(es, ec, eir, epc, edone, etrap, ecause);
    if (edone) exp_ret++;
    @(negedge clk);
  endtask

  task automatic fetch(input int fw);
    for (int i = 0; i <= fw; i++)
      step(i == fw, ro(), rb(), 3'd0, 11'h000, i == fw, i == fw, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic run_instr(input int op, input logic z, input int fw, input int mw);
    logic [10:0] w;
    w = word_tab[op];
    fetch(fw);
    step(rb(), OPW'(op), rb(), 3'd1, 11'h000, 1'b0, 1'b0, op == 9, 1'b0, 2'b00);
    if (op != 9) begin
      step(rb(), ro(), z, 3'd2, w & 11'h7F8, 1'b0, (op == 6) || (op == 5 && z),
           (op == 5) || (op == 6), 1'b0, 2'b00);
      if (op == 7 || op == 8)
        for (int j = 0; j <= mw; j++)
          step(j == mw, ro(), rb(), 3'd3, w & 11'h7FE, 1'b0, 1'b0, op == 7 && j == mw,
               1'b0, 2'b00);
      if ((op >= 1 && op <= 4) || op == 8)
        step(rb(), ro(), rb(), 3'd4, w & 11'h7F9, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    end
  endtask

  task automatic trap_cycles(input int n, input logic [1:0] cause);
    for (int i = 0; i < n; i++)
      step(rb(), ro(), rb(), 3'd7, 11'h000, 1'b0, 1'b0, 1'b0, 1'b1, cause);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    opcode    = ro();
    zero      = rb();
    exp_ret   = 0;
    #1;
    chk_all(3'd0, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    word_tab = '{default: 11'h000};
    word_tab[1] = 11'h001; word_tab[2] = 11'h249; word_tab[3] = 11'h251;
    word_tab[4] = 11'h259; word_tab[5] = 11'h538; word_tab[6] = 11'h4B8;
    word_tab[7] = 11'h24A; word_tab[8] = 11'h24D; word_tab[9] = 11'h038;

    @(negedge clk);
    do_reset();

    // load with mem_ready high: five states, WB shows bits 9,6,3,0
    run_instr(8, 1'b0, 0, 0);
    chk("load_retired", 32'(retired), 32'd1);
    run_instr(5, 1'b0, 0, 0);
    run_instr(5, 1'b1, 0, 0);
    run_instr(6, 1'b0, 0, 0);
    run_instr(7, 1'b0, 0, 2);
    run_instr(7, 1'b0, 1, 0);
    for (int i = 1; i <= 4; i++) run_instr(i, rb(), 0, 0);

    do_reset();
    for (int i = 0; i < 17; i++) run_instr(9, rb(), 0, 0);
    chk("noop_wrap", 32'(retired), 32'd1);

    for (int i = 0; i < 60; i++)
      run_instr($urandom_range(1, 9), rb(), $urandom_range(0, TMO - 1),
                $urandom_range(0, TMO - 1));

    // illegal opcodes trap with cause 01 and stay there
    do_reset();
    run_instr(9, 1'b0, 0, 0);
    fetch(0);
    step(rb(), OPW'(10), rb(), 3'd1, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    trap_cycles(20, 2'b01);
    do_reset();
    fetch(1);
    step(rb(), OPW'(0), rb(), 3'd1, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    trap_cycles(3, 2'b01);
    do_reset();
    fetch(0);
    step(rb(), OPW'(63), rb(), 3'd1, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    trap_cycles(3, 2'b01);

    // store whose memory never answers times out after TMO wait cycles
    do_reset();
    run_instr(2, 1'b0, 0, 0);
    fetch(0);
    step(rb(), OPW'(7), rb(), 3'd1, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    step(rb(), ro(), rb(), 3'd2, 11'h248, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    for (int j = 0; j < TMO; j++)
      step(1'b0, ro(), rb(), 3'd3, 11'h24A, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    trap_cycles(5, 2'b10);

    // fetch timeout
    do_reset();
    for (int j = 0; j < TMO; j++)
      step(1'b0, ro(), rb(), 3'd0, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    trap_cycles(4, 2'b10);

    // asynchronous reset in the middle of a MEM wait
    do_reset();
    run_instr(9, 1'b0, 0, 0);
    run_instr(1, 1'b0, 0, 0);
    fetch(0);
    step(rb(), OPW'(8), rb(), 3'd1, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    step(rb(), ro(), rb(), 3'd2, 11'h248, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    step(1'b0, ro(), rb(), 3'd3, 11'h24C, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    exp_ret = 0;
    #1;
    chk_all(3'd0, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(8, 1'b0, 0, 0);
    run_instr(7, 1'b0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
